// File: rtl/flxx_pkg.sv
// Shared types, field positions and helpers for the flxx decode stage.
package flxx_pkg;

  typedef enum logic [1:0] {
    ITYPE_RR  = 2'b00,
    ITYPE_IMM = 2'b01,
    ITYPE_RI  = 2'b10,
    ITYPE_SYS = 2'b11
  } itype_e;

  localparam int unsigned REG_AW         = 5;

  localparam int unsigned ITYPE_MSB      = 31;
  localparam int unsigned ITYPE_LSB      = 30;
  localparam int unsigned OPC_MSB        = 29;
  localparam int unsigned OPC_LSB        = 25;
  localparam int unsigned RD_MSB         = 24;
  localparam int unsigned RD_LSB         = 20;
  localparam int unsigned RS1_MSB        = 19;
  localparam int unsigned RS1_LSB        = 15;
  localparam int unsigned RS2_MSB        = 14;
  localparam int unsigned RS2_LSB        = 10;
  localparam int unsigned IMM_RD_MSB     = 28;
  localparam int unsigned IMM_RD_LSB     = 24;
  localparam int unsigned IMM_MSB        = 23;
  localparam int unsigned SIMM_MSB       = 14;

  // opcode[4] set marks a branch, which never writes a register
  localparam int unsigned OPC_BRANCH_BIT = 4;

  // True when the instruction will write a nonzero destination register
  function automatic logic is_writer(itype_e t, logic [4:0] opc, logic [4:0] rd);
    logic w;
    case (t)
      ITYPE_RR, ITYPE_RI: w = !opc[OPC_BRANCH_BIT];
      ITYPE_IMM:          w = 1'b1;
      default:            w = 1'b0;
    endcase
    return w && (rd != '0);
  endfunction

endpackage

// File: rtl/flxx_regfile.sv
// Architectural register file: 2 read ports, 1 write port, R0 hardwired to
// zero, same-cycle write data bypassed onto the read ports.
module flxx_regfile #(
  parameter int unsigned NREGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rd_addr1,
  output logic [31:0] rd_data1,
  input  logic [4:0]  rd_addr2,
  output logic [31:0] rd_data2,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data
);

  logic [31:0] regs [NREGS];

  // Register storage; writes to R0 are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read port 1 with write bypass
  always_comb begin
    rd_data1 = regs[rd_addr1];
    if (rd_addr1 == '0)                          rd_data1 = '0;
    else if (wr_en && (wr_addr == rd_addr1))     rd_data1 = wr_data;
  end

  // Read port 2 with write bypass
  always_comb begin
    rd_data2 = regs[rd_addr2];
    if (rd_addr2 == '0)                          rd_data2 = '0;
    else if (wr_en && (wr_addr == rd_addr2))     rd_data2 = wr_data;
  end

endmodule

// File: rtl/flxx_decode.sv
// Decode stage: field extraction, operand read, busy-register scoreboard
// and a single valid/ready output register toward execute.
module flxx_decode
  import flxx_pkg::*;
#(
  parameter int unsigned NREGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_itype,
  output logic [4:0]  out_opcode,
  output logic [4:0]  out_rd,
  output logic [31:0] out_reg1,
  output logic [31:0] out_reg2,
  output logic [23:0] out_imm,
  output logic [31:0] out_pc
);

  itype_e          dec_itype;
  logic [4:0]      dec_opc, dec_rd, dec_rs1, dec_rs2;
  logic [23:0]     dec_imm;
  logic            dec_wr;
  logic [31:0]     rf_rd1, rf_rd2;
  logic [31:0]     dec_reg1, dec_reg2;
  logic            rs1_blocked, rs2_blocked;
  logic            hazard, accept;
  logic [NREGS-1:0] busy, busy_nxt;
  logic            out_wr;

  flxx_regfile #(.NREGS(NREGS)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rd_addr1 (dec_rs1),
    .rd_data1 (rf_rd1),
    .rd_addr2 (dec_rs2),
    .rd_data2 (rf_rd2),
    .wr_en    (wb_en),
    .wr_addr  (wb_addr),
    .wr_data  (wb_data)
  );

  // Field extraction and operand selection for the presented instruction
  always_comb begin
    dec_itype = itype_e'(in_instr[ITYPE_MSB:ITYPE_LSB]);
    dec_opc   = in_instr[OPC_MSB:OPC_LSB];
    dec_rs1   = in_instr[RS1_MSB:RS1_LSB];
    dec_rs2   = in_instr[RS2_MSB:RS2_LSB];
    dec_rd    = in_instr[RD_MSB:RD_LSB];
    dec_imm   = '0;
    dec_reg1  = '0;
    dec_reg2  = '0;
    case (dec_itype)
      ITYPE_RR: begin
        dec_reg1 = rf_rd1;
        dec_reg2 = rf_rd2;
      end
      ITYPE_RI: begin
        dec_reg1 = rf_rd1;
        dec_reg2 = {{(31 - SIMM_MSB){in_instr[SIMM_MSB]}}, in_instr[SIMM_MSB:0]};
      end
      ITYPE_IMM: begin
        dec_rd  = in_instr[IMM_RD_MSB:IMM_RD_LSB];
        dec_imm = in_instr[IMM_MSB:0];
      end
      default: ;
    endcase
    dec_wr = is_writer(dec_itype, dec_opc, dec_rd);
  end

  // Read-after-write hazard; a same-cycle writeback releases the source
  always_comb begin
    rs1_blocked = (dec_rs1 != '0) && busy[dec_rs1] && !(wb_en && (wb_addr == dec_rs1));
    rs2_blocked = (dec_rs2 != '0) && busy[dec_rs2] && !(wb_en && (wb_addr == dec_rs2));
    hazard      = 1'b0;
    case (dec_itype)
      ITYPE_RR: hazard = rs1_blocked || rs2_blocked;
      ITYPE_RI: hazard = rs1_blocked;
      default:  hazard = 1'b0;
    endcase
    in_ready = (!out_valid || out_ready) && !hazard && !flush;
    accept   = in_valid && in_ready;
  end

  // Scoreboard next state: clears first so a coinciding set takes priority
  always_comb begin
    busy_nxt = busy;
    if (wb_en)                         busy_nxt[wb_addr] = 1'b0;
    if (flush && out_valid && out_wr)  busy_nxt[out_rd]  = 1'b0;
    if (accept && dec_wr)              busy_nxt[dec_rd]  = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  // Output payload register; flush has priority over consume and load
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_itype  <= '0;
      out_opcode <= '0;
      out_rd     <= '0;
      out_reg1   <= '0;
      out_reg2   <= '0;
      out_imm    <= '0;
      out_pc     <= '0;
      out_wr     <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_itype  <= dec_itype;
      out_opcode <= dec_opc;
      out_rd     <= dec_rd;
      out_reg1   <= dec_reg1;
      out_reg2   <= dec_reg2;
      out_imm    <= dec_imm;
      out_pc     <= in_pc;
      out_wr     <= dec_wr;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: doc/flxx_decode.md
FLXX_DECODE -- requirements
Module: flxx_decode

Interface
REQ-001 Parameter: NREGS, 32, architectural register count; register index width fixed at 5 bits.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 in_valid  in  1  fetch presents an instruction.
REQ-006 in_ready  out  1  decode accepts in_instr/in_pc this cycle.
REQ-007 in_instr  in  32  raw instruction word.
REQ-008 in_pc  in  32  address of in_instr.
REQ-009 wb_en  in  1  writeback strobe.
REQ-010 wb_addr  in  5  writeback register index.
REQ-011 wb_data  in  32  writeback data.
REQ-012 flush  in  1  drop the held instruction (taken jump).
REQ-013 out_valid  out  1  execute-side payload valid.
REQ-014 out_ready  in  1  execute stage consumes the payload.
REQ-015 out_itype  out  2 / out_opcode  out  5 / out_rd  out  5  decoded fields.
REQ-016 out_reg1, out_reg2  out  32 each  operands for the execute handler.
REQ-017 out_imm  out  24  instr[23:0] for itype 01.
REQ-018 out_pc  out  32  pc of the held instruction.

Function
REQ-019 Fields: itype=[31:30], opcode=[29:25], rd=[24:20], rs1=[19:15], rs2=[14:10]; for itype 01, rd=[28:24] and imm=[23:0].
REQ-020 Operands: itype 00 -> reg1=R[rs1], reg2=R[rs2]; itype 10 -> reg1=R[rs1], reg2=sign-extended instr[14:0]; itype 01/11 -> reg1=reg2=0.
REQ-021 R[0] SHALL read 0; writes to index 0 SHALL be ignored.
REQ-022 A read of index k with wb_en=1 and wb_addr=k (k!=0) in the same cycle SHALL return wb_data (write bypass).
REQ-023 Writer: itype 00/10 with opcode[4]=0, or itype 01, with rd!=0; branches (opcode[4]=1) and itype 11 do not write.
REQ-024 Busy scoreboard, one bit per register: set on accept of a writer for its rd; cleared on wb_en to that index; if set and clear coincide on one index, set wins.
REQ-025 Hazard when any used source (itype 00: rs1, rs2; itype 10: rs1) is nonzero, busy, and not cleared by a same-cycle wb_en.
REQ-026 in_ready = (!out_valid | out_ready) & !hazard & !flush; accept = in_valid & in_ready.
REQ-027 On accept, the output register SHALL load all out_* fields and set out_valid=1 on the next edge: 1-cycle latency.
REQ-028 out_valid & !out_ready SHALL hold all out_* fields stable.
REQ-029 out_valid & out_ready without accept SHALL clear out_valid next edge; with accept SHALL load the new payload (back-to-back, no bubble).
REQ-030 flush SHALL clear out_valid next edge, block accept that cycle, and clear busy[out_rd] if the held instruction was a writer; flush beats out_ready.
REQ-031 Operands SHALL be sampled at accept; later writebacks do not alter the held payload.

Reset
REQ-032 rst SHALL clear out_valid, all out_* fields, all busy bits and all register contents to 0; in_ready=1 the cycle after rst deasserts.
REQ-033 rst asserted mid-handshake SHALL discard the held instruction; rst beats flush, wb_en and in_valid.

Structure
REQ-034 Package flxx_pkg SHALL hold the itype enum (ITYPE_RR=00, ITYPE_IMM=01, ITYPE_RI=10, ITYPE_SYS=11), field-position localparams and the opcode[4] branch-bit constant.
REQ-035 Register storage with bypass SHALL be sub-module flxx_regfile (2 read, 1 write); scoreboard and pipeline register stay in flxx_decode.

Verification
REQ-036 wb R3=0x00000005, R4=0x0000000A; issue itype00 op 00001 rd=5 rs1=3 rs2=4 -> next cycle out_valid=1, reg1=5, reg2=0xA, rd=5, busy[5]=1.
REQ-037 Writer rd=5 then itype00 rs1=5 -> in_ready=0 until wb_en addr=5 data=0x77; that same cycle accept, reg1=0x77.
REQ-038 itype10 rs1=0, instr[14:0]=0x7FFF -> reg1=0, reg2=0xFFFFFFFF; rd=0 -> no busy bit set.
REQ-039 out_ready=0 for 3 cycles with writer held, then flush -> out_valid=0 next edge, fields unchanged while stalled, busy[rd] cleared.
REQ-040 Continuous in_valid, out_ready=1, no hazards, 8 instrs -> 8 payloads on 8 consecutive cycles, in order; rst mid-stream -> out_valid=0 and all busy bits 0 next edge.
